// File: rtl/axi4_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_stream_writer
//  Purpose  : Write-DMA stage. Accepts a (base address, beat count) command
//             plus a 64-bit data stream and writes it to memory over an AXI4
//             master port as INCR bursts of at most BURST_MAX beats, never
//             crossing a 4 KB boundary. One burst outstanding at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_stream_writer #(
    parameter int         BURST_MAX = 16,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    // command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_beats,
    // data stream
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic [7:0]  s_strb,
    // status
    output logic        busy,
    output logic        done,
    output logic        err,
    // AXI4 write address
    input  logic        m_axi_awready,
    output logic        m_axi_awvalid,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awid,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    // AXI4 write data
    input  logic        m_axi_wready,
    output logic        m_axi_wvalid,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    // AXI4 write response
    output logic        m_axi_bready,
    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    input  logic [3:0]  m_axi_bid,
    // AXI4 read address (unused)
    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [3:0]  m_axi_arqos,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    // AXI4 read data (unused)
    input  logic [3:0]  m_axi_rid,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [9:0] c_burst_max = 10'(BURST_MAX);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;        // address of the current burst (8-byte aligned)
    logic [15:0] r_remaining;   // beats still to write, including current burst
    logic [8:0]  r_n;           // beats in the current burst (1..256)
    logic [7:0]  r_beat;        // beats already transferred in the current burst
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [8:0]  w_n_minus1;
    logic [7:0]  w_awlen;
    logic        w_beat_fire;
    logic        w_last_beat;
    logic [31:0] w_addr_nxt;
    logic [15:0] w_remaining_nxt;
    logic        w_unused;

    // Burst length = min(remaining, BURST_MAX, beats left before the 4 KB page end).
    // The page distance is taken from the doubleword index within the page.
    function automatic logic [8:0] f_burst_beats(input logic [8:0]  dw_in_page,
                                                 input logic [15:0] remaining);
        logic [9:0] v_to_4k;
        logic [9:0] v_cap;
        v_to_4k = 10'd512 - {1'b0, dw_in_page};
        v_cap   = (v_to_4k < c_burst_max) ? v_to_4k : c_burst_max;
        if ({6'd0, v_cap} < remaining)
            return v_cap[8:0];
        else
            return remaining[8:0];
    endfunction

    assign w_n_minus1      = r_n - 9'd1;
    assign w_awlen         = w_n_minus1[7:0];
    assign w_beat_fire     = (r_state == ST_W) && s_valid && m_axi_wready;
    assign w_last_beat     = (r_beat == w_awlen);
    assign w_addr_nxt      = r_addr + {20'd0, r_n, 3'b000};
    assign w_remaining_nxt = r_remaining - {7'd0, r_n};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_ready       = 1'b0;
        m_axi_bready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_state_nxt = (cmd_beats != 16'd0) ? ST_AW : ST_DONE;
            end
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready)
                    w_state_nxt = ST_W;
            end
            ST_W: begin
                m_axi_wvalid = s_valid;
                s_ready      = m_axi_wready;
                m_axi_wlast  = w_last_beat;
                if (w_beat_fire && w_last_beat)
                    w_state_nxt = ST_B;
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid)
                    w_state_nxt = (w_remaining_nxt == 16'd0) ? ST_DONE : ST_AW;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command datapath: address/remaining bookkeeping, burst sizing and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_n         <= 9'd1;
            r_beat      <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= {cmd_addr[31:3], 3'b000};
                        r_remaining <= cmd_beats;
                        r_n         <= f_burst_beats(cmd_addr[11:3], cmd_beats);
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_AW: begin
                    r_beat <= 8'd0;
                end
                ST_W: begin
                    if (w_beat_fire)
                        r_beat <= r_beat + 8'd1;
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        r_err       <= r_err | (m_axi_bresp != 2'b00);
                        r_addr      <= w_addr_nxt;
                        r_remaining <= w_remaining_nxt;
                        r_n         <= f_burst_beats(w_addr_nxt[11:3], w_remaining_nxt);
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = w_awlen;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;

    assign m_axi_wdata   = s_data;
    assign m_axi_wstrb   = s_strb;

    // Read channel is never used
    assign m_axi_arid    = 4'd0;
    assign m_axi_araddr  = 32'd0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd0;
    assign m_axi_arburst = 2'd0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;

    assign w_unused = &{1'b0, cmd_addr[2:0], m_axi_bid, m_axi_arready, m_axi_rid,
                        m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, w_n_minus1[8]};

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_stream_writer
//  Purpose  : Directed self-checking bench for axi4_stream_writer with a
//             simple AXI4 write-slave model that logs every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_stream_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [7:0]  s_strb;
    logic        busy;
    logic        done;
    logic        err;
    logic        m_axi_awready;
    logic        m_axi_awvalid;
    logic [31:0] m_axi_awaddr;
    logic [3:0]  m_axi_awid;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wready;
    logic        m_axi_wvalid;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bready;
    logic        m_axi_bvalid;
    logic [1:0]  m_axi_bresp;
    logic [3:0]  m_axi_bid;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks;
    int failures;

    // slave-model controls (written by the test sequence only)
    bit aw_stall;
    bit w_stall;
    int err_burst;

    // slave-model logs (written by the slave process only)
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [2:0]  aw_size_q[$];
    logic [1:0]  aw_burst_q[$];
    logic [3:0]  aw_id_q[$];
    logic [63:0] w_data_q[$];
    logic [7:0]  w_strb_q[$];
    logic        w_last_q[$];
    int          w_cyc_q[$];
    int          aw_count;
    int          wl_count;
    int          b_pending;
    int          b_count;
    int          w_early;
    int          cyc_count;

    axi4_stream_writer #(.BURST_MAX(16), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
        .busy(busy), .done(done), .err(err),
        .m_axi_awready(m_axi_awready), .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_wready(m_axi_wready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bready(m_axi_bready), .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bid(m_axi_bid),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream contents: a per-test tag plus the beat index
    function automatic logic [63:0] beat_word(input logic [7:0] tag, input int i);
        return {tag, 24'h5A5A5A, 32'(i) ^ 32'hC0DE0000};
    endfunction

    function automatic logic [7:0] beat_strb(input int i);
        return 8'(i * 37 + 1);
    endfunction

    // AXI write slave: drive on the falling edge, log handshakes just before the rising edge
    always begin
        @(negedge clk);
        m_axi_awready = aw_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axi_wready  = w_stall  ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_bvalid  = (b_pending > 0);
        m_axi_bresp   = (b_count + 1 == err_burst) ? 2'b10 : 2'b00;
        #4;
        cyc_count++;
        if (rst_n) begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_q.push_back(m_axi_awaddr);
                aw_len_q.push_back(m_axi_awlen);
                aw_size_q.push_back(m_axi_awsize);
                aw_burst_q.push_back(m_axi_awburst);
                aw_id_q.push_back(m_axi_awid);
                aw_count++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (aw_count <= wl_count) w_early++;
                w_data_q.push_back(m_axi_wdata);
                w_strb_q.push_back(m_axi_wstrb);
                w_last_q.push_back(m_axi_wlast);
                w_cyc_q.push_back(cyc_count);
                if (m_axi_wlast) begin
                    wl_count++;
                    b_pending++;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending--;
                b_count++;
            end
        end
    end

    // Issue one command and feed its stream; returns cycles from accept to done (-1 on timeout)
    task automatic run_cmd(input logic [31:0] addr, input logic [15:0] beats, input bit stall,
                           input logic [7:0] tag, output int done_cyc, output logic err_done,
                           output logic err_acc, output logic busy_acc, output int sent);
        int cyc;
        int acc_cyc;
        bit accepted;
        bit hold;
        cyc = 0; acc_cyc = -1; accepted = 0; hold = 0; sent = 0;
        done_cyc = -1; err_done = 1'bx; err_acc = 1'bx; busy_acc = 1'bx;
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cmd_valid = !accepted;
            cmd_addr  = addr;
            cmd_beats = beats;
            if (!hold) begin
                s_valid = accepted && (sent < int'(beats)) && (!stall || $urandom_range(0, 3) != 0);
                s_data  = beat_word(tag, sent);
                s_strb  = beat_strb(sent);
            end
            #4;
            if (accepted && cyc == acc_cyc + 1) begin
                err_acc  = err;
                busy_acc = busy;
            end
            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (s_valid && s_ready) begin
                sent++;
                hold = 0;
            end else begin
                hold = s_valid;
            end
            if (accepted && done) begin
                done_cyc = cyc - acc_cyc;
                err_done = err;
            end
            cyc++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        s_valid = 1'b0; s_data = '0; s_strb = '0;
        m_axi_bid = '0; m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #4;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (m_axi_awvalid !== 1'b0) begin failures++; $display("FAIL rst_awvalid got=%b exp=0", m_axi_awvalid); end
        checks++; if (m_axi_wvalid !== 1'b0) begin failures++; $display("FAIL rst_wvalid got=%b exp=0", m_axi_wvalid); end
        checks++; if (m_axi_bready !== 1'b0) begin failures++; $display("FAIL rst_bready got=%b exp=0", m_axi_bready); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {busy, done, err}); end
        checks++;
        if ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
             m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready} !== '0) begin
            failures++; $display("FAIL rst_read_channel got=nonzero exp=0");
        end
    endtask

    task automatic test_single_burst;
        int aw0, w0, e0, dc, sent;
        logic ed, ea, ba;
        aw0 = aw_addr_q.size(); w0 = w_data_q.size(); e0 = w_early;
        run_cmd(32'h0000_1000, 16'd4, 1'b0, 8'h11, dc, ed, ea, ba, sent);
        checks++; if (aw_addr_q.size() !== aw0 + 1) begin failures++; $display("FAIL t1_aw_count got=%0d exp=%0d", aw_addr_q.size() - aw0, 1); end
        if (aw_addr_q.size() > aw0) begin
            checks++; if (aw_addr_q[aw0] !== 32'h1000) begin failures++; $display("FAIL t1_awaddr got=%h exp=00001000", aw_addr_q[aw0]); end
            checks++; if (aw_len_q[aw0] !== 8'd3) begin failures++; $display("FAIL t1_awlen got=%0d exp=3", aw_len_q[aw0]); end
            checks++;
            if ({aw_size_q[aw0], aw_burst_q[aw0], aw_id_q[aw0]} !== {3'b011, 2'b01, 4'd0}) begin
                failures++; $display("FAIL t1_aw_const got=%b/%b/%h exp=011/01/0", aw_size_q[aw0], aw_burst_q[aw0], aw_id_q[aw0]);
            end
        end
        checks++; if (w_data_q.size() !== w0 + 4) begin failures++; $display("FAIL t1_w_count got=%0d exp=4", w_data_q.size() - w0); end
        for (int k = 0; k < 4 && w0 + k < w_data_q.size(); k++) begin
            checks++;
            if (w_data_q[w0+k] !== beat_word(8'h11, k) || w_strb_q[w0+k] !== beat_strb(k) || w_last_q[w0+k] !== (k == 3)) begin
                failures++; $display("FAIL t1_beat%0d got=%h/%h/%b exp=%h/%h/%b", k, w_data_q[w0+k], w_strb_q[w0+k],
                                     w_last_q[w0+k], beat_word(8'h11, k), beat_strb(k), (k == 3));
            end
            if (k > 0) begin
                checks++;
                if (w_cyc_q[w0+k] !== w_cyc_q[w0+k-1] + 1) begin
                    failures++; $display("FAIL t1_bubble%0d got=%0d exp=%0d", k, w_cyc_q[w0+k], w_cyc_q[w0+k-1] + 1);
                end
            end
        end
        checks++; if (dc <= 0) begin failures++; $display("FAIL t1_done got=%0d exp=>0", dc); end
        checks++; if (ed !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", ed); end
        checks++; if (w_early !== e0) begin failures++; $display("FAIL t1_w_before_aw got=%0d exp=%0d", w_early, e0); end
    endtask

    task automatic test_boundary_split;
        int aw0, w0, dc, sent;
        logic ed, ea, ba;
        logic [31:0] exp_addr[4];
        logic [7:0]  exp_len[4];
        exp_addr = '{32'h0FF0, 32'h1000, 32'h1080, 32'h1100};
        exp_len  = '{8'd1, 8'd15, 8'd15, 8'd5};
        aw0 = aw_addr_q.size(); w0 = w_data_q.size();
        run_cmd(32'h0000_0FF0, 16'd40, 1'b0, 8'h22, dc, ed, ea, ba, sent);
        checks++; if (aw_addr_q.size() !== aw0 + 4) begin failures++; $display("FAIL t2_aw_count got=%0d exp=4", aw_addr_q.size() - aw0); end
        for (int b = 0; b < 4 && aw0 + b < aw_addr_q.size(); b++) begin
            checks++;
            if (aw_addr_q[aw0+b] !== exp_addr[b] || aw_len_q[aw0+b] !== exp_len[b]) begin
                failures++; $display("FAIL t2_burst%0d got=%h/%0d exp=%h/%0d", b, aw_addr_q[aw0+b], aw_len_q[aw0+b], exp_addr[b], exp_len[b]);
            end
        end
        checks++; if (w_data_q.size() !== w0 + 40) begin failures++; $display("FAIL t2_w_count got=%0d exp=40", w_data_q.size() - w0); end
        for (int k = 0; k < 40 && w0 + k < w_data_q.size(); k++) begin
            checks++;
            if (w_data_q[w0+k] !== beat_word(8'h22, k) || w_last_q[w0+k] !== (k == 1 || k == 17 || k == 33 || k == 39)) begin
                failures++; $display("FAIL t2_beat%0d got=%h/%b exp=%h/%b", k, w_data_q[w0+k], w_last_q[w0+k],
                                     beat_word(8'h22, k), (k == 1 || k == 17 || k == 33 || k == 39));
            end
        end
        checks++; if (dc <= 0 || ed !== 1'b0) begin failures++; $display("FAIL t2_done got=%0d/%b exp=>0/0", dc, ed); end
    endtask

    task automatic test_stalls;
        int aw0, w0, e0, dc, sent;
        logic ed, ea, ba;
        aw0 = aw_addr_q.size(); w0 = w_data_q.size(); e0 = w_early;
        aw_stall = 1'b1; w_stall = 1'b1;
        run_cmd(32'h0000_2000, 16'd20, 1'b1, 8'h33, dc, ed, ea, ba, sent);
        aw_stall = 1'b0; w_stall = 1'b0;
        checks++; if (aw_addr_q.size() !== aw0 + 2) begin failures++; $display("FAIL t3_aw_count got=%0d exp=2", aw_addr_q.size() - aw0); end
        if (aw_addr_q.size() >= aw0 + 2) begin
            checks++;
            if (aw_addr_q[aw0] !== 32'h2000 || aw_len_q[aw0] !== 8'd15 || aw_addr_q[aw0+1] !== 32'h2080 || aw_len_q[aw0+1] !== 8'd3) begin
                failures++; $display("FAIL t3_bursts got=%h/%0d,%h/%0d exp=00002000/15,00002080/3",
                                     aw_addr_q[aw0], aw_len_q[aw0], aw_addr_q[aw0+1], aw_len_q[aw0+1]);
            end
        end
        checks++; if (w_data_q.size() !== w0 + 20) begin failures++; $display("FAIL t3_w_count got=%0d exp=20", w_data_q.size() - w0); end
        for (int k = 0; k < 20 && w0 + k < w_data_q.size(); k++) begin
            checks++;
            if (w_data_q[w0+k] !== beat_word(8'h33, k) || w_strb_q[w0+k] !== beat_strb(k) || w_last_q[w0+k] !== (k == 15 || k == 19)) begin
                failures++; $display("FAIL t3_beat%0d got=%h/%h/%b exp=%h/%h/%b", k, w_data_q[w0+k], w_strb_q[w0+k], w_last_q[w0+k],
                                     beat_word(8'h33, k), beat_strb(k), (k == 15 || k == 19));
            end
        end
        checks++; if (dc <= 0 || ed !== 1'b0 || sent !== 20) begin failures++; $display("FAIL t3_done got=%0d/%b/%0d exp=>0/0/20", dc, ed, sent); end
        checks++; if (w_early !== e0) begin failures++; $display("FAIL t3_w_before_aw got=%0d exp=%0d", w_early, e0); end
    endtask

    task automatic test_bresp_error;
        int aw0, b0, dc, sent;
        logic ed, ea, ba;
        aw0 = aw_addr_q.size(); b0 = b_count;
        err_burst = b0 + 2;
        run_cmd(32'h0000_3000, 16'd40, 1'b0, 8'h44, dc, ed, ea, ba, sent);
        err_burst = 0;
        checks++; if (aw_addr_q.size() !== aw0 + 3) begin failures++; $display("FAIL t4_aw_count got=%0d exp=3", aw_addr_q.size() - aw0); end
        if (aw_addr_q.size() >= aw0 + 3) begin
            checks++;
            if (aw_addr_q[aw0+2] !== 32'h3100 || aw_len_q[aw0+2] !== 8'd7) begin
                failures++; $display("FAIL t4_burst3 got=%h/%0d exp=00003100/7", aw_addr_q[aw0+2], aw_len_q[aw0+2]);
            end
        end
        checks++; if (b_count !== b0 + 3) begin failures++; $display("FAIL t4_b_count got=%0d exp=3", b_count - b0); end
        checks++; if (dc <= 0 || ed !== 1'b1) begin failures++; $display("FAIL t4_err_at_done got=%0d/%b exp=>0/1", dc, ed); end
        repeat (3) @(negedge clk);
        #4;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL t4_err_held got=%b exp=1", err); end
        run_cmd(32'h0000_3800, 16'd4, 1'b0, 8'h45, dc, ed, ea, ba, sent);
        checks++; if (ea !== 1'b0) begin failures++; $display("FAIL t4_err_clear_on_accept got=%b exp=0", ea); end
        checks++; if (dc <= 0 || ed !== 1'b0) begin failures++; $display("FAIL t4_next_done got=%0d/%b exp=>0/0", dc, ed); end
    endtask

    task automatic test_zero_beats;
        int aw0, w0, dc, sent;
        logic ed, ea, ba;
        aw0 = aw_addr_q.size(); w0 = w_data_q.size();
        run_cmd(32'h0000_6000, 16'd0, 1'b0, 8'h55, dc, ed, ea, ba, sent);
        checks++; if (dc !== 2) begin failures++; $display("FAIL t5_done_latency got=%0d exp=2", dc); end
        checks++; if (ba !== 1'b1) begin failures++; $display("FAIL t5_busy got=%b exp=1", ba); end
        checks++; if (ed !== 1'b0) begin failures++; $display("FAIL t5_err got=%b exp=0", ed); end
        checks++;
        if (aw_addr_q.size() !== aw0 || w_data_q.size() !== w0) begin
            failures++; $display("FAIL t5_no_traffic got=%0d/%0d exp=0/0", aw_addr_q.size() - aw0, w_data_q.size() - w0);
        end
    endtask

    task automatic test_async_reset;
        int aw0, w0, dc, sent, cyc;
        logic ed, ea, ba;
        aw0 = aw_addr_q.size(); w0 = w_data_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_beats = 16'd8;
        #4;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL t6_accept got=%b exp=1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 2 && cyc < 50) begin
            s_valid = 1'b1; s_data = beat_word(8'h66, sent); s_strb = beat_strb(sent);
            #4;
            if (s_valid && s_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b1; s_data = beat_word(8'h66, sent); s_strb = beat_strb(sent);
        #1;
        checks++; if (m_axi_wvalid !== 1'b1) begin failures++; $display("FAIL t6_mid_burst got=%b exp=1", m_axi_wvalid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, s_ready, busy, cmd_ready} !== 5'b00001) begin
            failures++; $display("FAIL t6_reset_drop got=%b exp=00001", {m_axi_awvalid, m_axi_wvalid, s_ready, busy, cmd_ready});
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b1;
        run_cmd(32'h0000_5000, 16'd4, 1'b0, 8'h67, dc, ed, ea, ba, sent);
        checks++; if (aw_addr_q.size() !== aw0 + 2) begin failures++; $display("FAIL t6_aw_count got=%0d exp=2", aw_addr_q.size() - aw0); end
        if (aw_addr_q.size() >= aw0 + 2) begin
            checks++;
            if (aw_addr_q[aw0+1] !== 32'h5000 || aw_len_q[aw0+1] !== 8'd3) begin
                failures++; $display("FAIL t6_new_aw got=%h/%0d exp=00005000/3", aw_addr_q[aw0+1], aw_len_q[aw0+1]);
            end
        end
        checks++; if (w_data_q.size() !== w0 + 6) begin failures++; $display("FAIL t6_w_count got=%0d exp=6", w_data_q.size() - w0); end
        for (int k = 0; k < 4 && w0 + 2 + k < w_data_q.size(); k++) begin
            checks++;
            if (w_data_q[w0+2+k] !== beat_word(8'h67, k) || w_last_q[w0+2+k] !== (k == 3)) begin
                failures++; $display("FAIL t6_beat%0d got=%h/%b exp=%h/%b", k, w_data_q[w0+2+k], w_last_q[w0+2+k], beat_word(8'h67, k), (k == 3));
            end
        end
        checks++; if (dc <= 0 || ed !== 1'b0) begin failures++; $display("FAIL t6_done got=%0d/%b exp=>0/0", dc, ed); end
    endtask

    // Test sequence
    initial begin
        checks = 0; failures = 0;
        aw_stall = 1'b0; w_stall = 1'b0; err_burst = 0;
        test_reset();
        test_single_burst();
        test_boundary_split();
        test_stalls();
        test_bresp_error();
        test_zero_beats();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
